// File: rtl/fetch_pc_unit.sv
// Program-counter / fetch-control stage: IDLE/RUN/DONE run handshake, branch
// target selection, stall/halt handling and a saturating retired-instruction count.
module fetch_pc_unit #(
  parameter int PW = 10,
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  input  logic          BranchEn,
  input  logic          BranchCond,
  input  logic          JumpAbs,
  input  logic [W-1:0]  JumpReg,
  input  logic          Stall,
  output logic [PW-1:0] PC,
  output logic          Running,
  output logic          Done,
  output logic          Taken,
  output logic [CW-1:0] InstrCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state, w_state_nx;
  logic          r_armed, w_armed_nx;
  logic [PW-1:0] r_pc, w_pc_nx;
  logic          r_taken, w_taken_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [CW-1:0] w_cnt_inc;
  logic [PW-1:0] w_target;

  // Relative offsets are sign-extended; PC arithmetic wraps modulo 2^PW.
  assign w_target  = JumpAbs ? PW'(JumpReg) : r_pc + PW'($signed(JumpReg));
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_armed <= 1'b0;
      r_pc    <= '0;
      r_taken <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_armed <= w_armed_nx;
      r_pc    <= w_pc_nx;
      r_taken <= w_taken_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_armed_nx = r_armed;
    w_pc_nx    = r_pc;
    w_taken_nx = 1'b0;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        w_pc_nx = '0;
        if (Start) begin
          w_armed_nx = 1'b1;
          w_cnt_nx   = '0;
        end else if (r_armed) begin
          w_state_nx = S_RUN;
          w_armed_nx = 1'b0;
        end
      end
      S_RUN: begin
        if (Start) begin
          w_state_nx = S_IDLE;
          w_pc_nx    = '0;
          w_cnt_nx   = '0;
          w_armed_nx = 1'b1;
        end else if (Stall) begin
          w_taken_nx = 1'b0;
        end else if (Halt) begin
          w_state_nx = S_DONE;
          w_cnt_nx   = w_cnt_inc;
        end else if (BranchEn && BranchCond) begin
          w_pc_nx    = w_target;
          w_taken_nx = 1'b1;
          w_cnt_nx   = w_cnt_inc;
        end else begin
          w_pc_nx  = r_pc + PW'(1);
          w_cnt_nx = w_cnt_inc;
        end
      end
      S_DONE: begin
        if (Start) begin
          w_state_nx = S_IDLE;
          w_pc_nx    = '0;
          w_cnt_nx   = '0;
          w_armed_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_pc_nx    = '0;
      end
    endcase
  end

  assign PC         = r_pc;
  assign Taken      = r_taken;
  assign InstrCount = r_cnt;
  assign Running    = (r_state == S_RUN);
  assign Done       = (r_state == S_DONE);

endmodule
